// File: rtl/mdio_pkg.sv
// Shared Clause 22 frame constants, bit positions and responder FSM state type.
package mdio_pkg;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  // Index of the last bit of each field, counted from ST b0 after the preamble.
  localparam logic [4:0] BIT_ST_END    = 5'd1;
  localparam logic [4:0] BIT_OP_END    = 5'd3;
  localparam logic [4:0] BIT_PHYAD_END = 5'd8;
  localparam logic [4:0] BIT_REGAD_END = 5'd13;
  localparam logic [4:0] BIT_TA_FIRST  = 5'd14;
  localparam logic [4:0] BIT_TA_END    = 5'd15;
  localparam logic [4:0] BIT_DATA_END  = 5'd31;

  typedef enum logic [2:0] {
    IDLE,
    ST,
    OP,
    PHYAD,
    REGAD,
    TA,
    DATA,
    SKIP
  } mdio_state_e;

  function automatic logic is_c22_op(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// Synchronizes MDC/MDIO into clk and flags the synchronized MDC rising edge.
module mdio_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mdc,
  input  logic mdio_i,
  output logic rise,
  output logic mdio_s
);

  logic [SYNC_STAGES-1:0] mdc_sync_reg;
  logic [SYNC_STAGES-1:0] mdc_sync_next;
  logic [SYNC_STAGES-1:0] mdio_sync_reg;
  logic [SYNC_STAGES-1:0] mdio_sync_next;
  logic                   mdc_prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign mdc_sync_next[gi]  = mdc;
        assign mdio_sync_next[gi] = mdio_i;
      end else begin : g_rest
        assign mdc_sync_next[gi]  = mdc_sync_reg[gi-1];
        assign mdio_sync_next[gi] = mdio_sync_reg[gi-1];
      end
    end
  endgenerate

  // Reset high so a line already high at reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_sync_reg  <= '1;
      mdio_sync_reg <= '1;
      mdc_prev_reg  <= 1'b1;
    end else begin
      mdc_sync_reg  <= mdc_sync_next;
      mdio_sync_reg <= mdio_sync_next;
      mdc_prev_reg  <= mdc_sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise   = mdc_sync_reg[SYNC_STAGES-1] & ~mdc_prev_reg;
  assign mdio_s = mdio_sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_slave.sv
// Clause 22 MDIO responder: decodes frames for phy_addr and drives a register strobe interface.
module mdio_slave
  import mdio_pkg::*;
#(
  parameter int PREAMBLE_MIN = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  phy_addr,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic [4:0]  reg_addr,
  output logic        reg_rd_req,
  input  logic [15:0] reg_rd_data,
  output logic        reg_wr_valid,
  output logic [15:0] reg_wr_data,
  output logic        busy,
  output logic        frame_err
);

  localparam int PRE_W = (PREAMBLE_MIN < 1) ? 1 : $clog2(PREAMBLE_MIN + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PREAMBLE_MIN);

  logic        rise;
  logic        mdio_s;

  mdio_state_e state_reg;
  logic [PRE_W-1:0] pre_cnt_reg;
  logic [4:0]  bit_idx_reg;
  logic [14:0] shift_reg;
  logic [15:0] rd_shift_reg;
  logic        is_read_reg;
  logic        rd_latch_reg;

  mdio_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .mdc    (mdc),
    .mdio_i (mdio_i),
    .rise   (rise),
    .mdio_s (mdio_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pre_cnt_reg  <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      rd_shift_reg <= '0;
      is_read_reg  <= 1'b0;
      rd_latch_reg <= 1'b0;
      mdio_o       <= 1'b1;
      mdio_t       <= 1'b1;
      reg_addr     <= '0;
      reg_rd_req   <= 1'b0;
      reg_wr_valid <= 1'b0;
      reg_wr_data  <= '0;
      busy         <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      reg_rd_req   <= 1'b0;
      reg_wr_valid <= 1'b0;
      frame_err    <= 1'b0;
      // Register bank answers one clk after the request; capture on the clk after that.
      rd_latch_reg <= reg_rd_req;
      if (rd_latch_reg) begin
        rd_shift_reg <= reg_rd_data;
      end

      if (rise) begin
        bit_idx_reg <= bit_idx_reg + 5'd1;
        shift_reg   <= {shift_reg[13:0], mdio_s};
        case (state_reg)
          IDLE: begin
            bit_idx_reg <= 5'd1;
            if (mdio_s) begin
              if (pre_cnt_reg != PRE_MAX) begin
                pre_cnt_reg <= pre_cnt_reg + 1'b1;
              end
            end else if (pre_cnt_reg == PRE_MAX) begin
              state_reg   <= ST;
              busy        <= 1'b1;
              pre_cnt_reg <= '0;
            end else begin
              pre_cnt_reg <= '0;
            end
          end
          ST: begin
            if (mdio_s == ST_CODE[0]) begin
              state_reg <= OP;
            end else begin
              frame_err <= 1'b1;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end
          end
          OP: begin
            if (bit_idx_reg == BIT_OP_END) begin
              is_read_reg <= ({shift_reg[0], mdio_s} == OP_READ);
              if (is_c22_op({shift_reg[0], mdio_s})) begin
                state_reg <= PHYAD;
              end else begin
                frame_err <= 1'b1;
                state_reg <= SKIP;
              end
            end
          end
          PHYAD: begin
            if (bit_idx_reg == BIT_PHYAD_END) begin
              state_reg <= ({shift_reg[3:0], mdio_s} == phy_addr) ? REGAD : SKIP;
            end
          end
          REGAD: begin
            if (bit_idx_reg == BIT_REGAD_END) begin
              reg_addr   <= {shift_reg[3:0], mdio_s};
              reg_rd_req <= is_read_reg;
              state_reg  <= TA;
            end
          end
          TA: begin
            if (bit_idx_reg == BIT_TA_FIRST) begin
              if (is_read_reg) begin
                mdio_t <= 1'b0;
                mdio_o <= 1'b0;
              end
            end else begin
              if (is_read_reg) begin
                mdio_o       <= rd_shift_reg[15];
                rd_shift_reg <= {rd_shift_reg[14:0], 1'b0};
              end
              state_reg <= DATA;
            end
          end
          DATA: begin
            if (bit_idx_reg == BIT_DATA_END) begin
              mdio_t      <= 1'b1;
              mdio_o      <= 1'b1;
              busy        <= 1'b0;
              pre_cnt_reg <= '0;
              state_reg   <= IDLE;
              if (!is_read_reg) begin
                reg_wr_valid <= 1'b1;
                reg_wr_data  <= {shift_reg, mdio_s};
              end
            end else if (is_read_reg) begin
              mdio_o       <= rd_shift_reg[15];
              rd_shift_reg <= {rd_shift_reg[14:0], 1'b0};
            end
          end
          SKIP: begin
            if (bit_idx_reg == BIT_DATA_END) begin
              busy        <= 1'b0;
              pre_cnt_reg <= '0;
              state_reg   <= IDLE;
            end
          end
          default: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
